// File: rtl/soc_mem_arbiter_if.sv
// rtl/soc_mem_arbiter_if.sv - PicoRV32-style native memory bus channel
// One instance per master; the arbiter takes the slave side.
interface soc_mem_arbiter_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/soc_mem_arbiter.sv
// rtl/soc_mem_arbiter.sv - two-master arbiter in front of a single-port synchronous SRAM
// Fixed priority (M0 wins ties) by default; define MEM_ARB_RR_EN for round-robin ties.
module soc_mem_arbiter #(
  parameter int MEM_WORDS = 32768,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  soc_mem_arbiter_if.slave m0,
  soc_mem_arbiter_if.slave m1,
  output logic             sram_en_o,
  output logic [3:0]       sram_we_o,
  output logic [AW-1:0]    sram_addr_o,
  output logic [31:0]      sram_wdata_o,
  input  logic [31:0]      sram_rdata_i,
  output logic             bus_err_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, RESP0, RESP1} state_e;

  state_e      state_q, state_d;
  logic        err_q, err_d;
  logic        any_valid;
  logic        grant1;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        in_range;
  logic [1:0]  unused_byte_offset;

  assign any_valid = m0.valid | m1.valid;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;  // 1 = M1 was granted last
  assign grant1 = m1.valid & (~m0.valid | ~last_grant_q);
`else
  assign grant1 = m1.valid & ~m0.valid;
`endif

  assign sel_addr           = grant1 ? m1.addr  : m0.addr;
  assign sel_wdata          = grant1 ? m1.wdata : m0.wdata;
  assign sel_wstrb          = grant1 ? m1.wstrb : m0.wstrb;
  assign unused_byte_offset = sel_addr[1:0];
  // Full-width word compare: no aliasing of high addresses into the array.
  assign in_range = ({2'b00, sel_addr[31:2]} < 32'(MEM_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      err_q        <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    state_d      = IDLE;
    err_d        = err_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d      = grant1 ? RESP1 : RESP0;
          err_d        = ~in_range;
`ifdef MEM_ARB_RR_EN
          last_grant_d = grant1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM is strobed in the grant cycle; the response slot returns its data.
  always_comb begin
    sram_en_o    = 1'b0;
    sram_we_o    = 4'b0000;
    sram_addr_o  = '0;
    sram_wdata_o = 32'h0;
    m0.ready     = 1'b0;
    m0.rdata     = 32'h0;
    m1.ready     = 1'b0;
    m1.rdata     = 32'h0;
    bus_err_o    = 1'b0;
    busy_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          sram_en_o    = in_range;
          sram_we_o    = in_range ? sel_wstrb : 4'b0000;
          sram_addr_o  = sel_addr[AW+1:2];
          sram_wdata_o = sel_wdata;
        end
      end
      RESP0: begin
        busy_o    = 1'b1;
        m0.ready  = 1'b1;
        m0.rdata  = err_q ? 32'h0 : sram_rdata_i;
        bus_err_o = err_q;
      end
      RESP1: begin
        busy_o    = 1'b1;
        m1.ready  = 1'b1;
        m1.rdata  = err_q ? 32'h0 : sram_rdata_i;
        bus_err_o = err_q;
      end
      default: busy_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// tb/tb_soc_mem_arbiter.sv - scoreboard bench for soc_mem_arbiter
// Reference memory and grant order are modelled from the arbitration rules.
module tb_soc_mem_arbiter;
  localparam int MEM_WORDS = 32768;
  localparam int AW        = $clog2(MEM_WORDS);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  soc_mem_arbiter_if m0_if ();
  soc_mem_arbiter_if m1_if ();

  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;
  logic          bus_err;
  logic          busy;

  soc_mem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0           (m0_if),
    .m1           (m1_if),
    .sram_en_o    (sram_en),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata),
    .bus_err_o    (bus_err),
    .busy_o       (busy)
  );

  typedef struct {
    int          master;
    bit          err;
    bit          chk_data;
    logic [31:0] rdata;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;
  int          model_lg = 1;
  exp_t        sb[$];
  logic [31:0] ref_mem[int];
  logic [31:0] sram_mem[MEM_WORDS];

  function automatic logic [31:0] preload(int w);
    if (w == 5) return 32'hDEADBEEF;
    return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) sram_mem[i] = preload(i);
    sram_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      sram_rdata <= sram_mem[sram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >> 2) < MEM_WORDS;
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : preload(w);
  endfunction

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef MEM_ARB_RR_EN
      return 1 - model_lg;
`else
      return 0;
`endif
    end
    return r0 ? 0 : 1;
  endfunction

  function automatic exp_t model_access(input int m, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] wstrb);
    exp_t        e;
    int          w;
    logic [31:0] v;
    bit          ok;
    ok         = in_rng(addr);
    w          = int'(addr >> 2);
    e.master   = m;
    e.err      = !ok;
    e.chk_data = (wstrb == 4'b0) || !ok;
    e.rdata    = ok ? ref_rd(w) : 32'h0;
    if (ok && wstrb != 4'b0) begin
      v = ref_rd(w);
      for (int b = 0; b < 4; b++) if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
      ref_mem[w] = v;
    end
    model_lg = m;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   gm;
    if (mon_en) begin
      if (!m0_if.ready) check("m0_rdata_zero", m0_if.rdata, 32'h0);
      if (!m1_if.ready) check("m1_rdata_zero", m1_if.rdata, 32'h0);
      if (m0_if.ready || m1_if.ready) begin
        check("one_ready", 32'(m0_if.ready & m1_if.ready), 32'h0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got m0=%b m1=%b expected no response", m0_if.ready, m1_if.ready);
        end else begin
          e  = sb.pop_front();
          gm = m1_if.ready ? 1 : 0;
          check("grant_master", 32'(gm), 32'(e.master));
          check("bus_err", 32'(bus_err), 32'(e.err));
          if (e.chk_data) check("rdata", gm == 1 ? m1_if.rdata : m0_if.rdata, e.rdata);
        end
      end else begin
        check("bus_err_idle", 32'(bus_err), 32'h0);
      end
    end
  end

  task automatic do_round(input bit r0, input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] s0,
                          input bit r1, input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] s1);
    int          first, n;
    bit          p0, p1;
    logic [31:0] sa;
    logic [3:0]  ss;
    first = pick(r0, r1);
    if (first == 0 && r0) sb.push_back(model_access(0, a0, d0, s0));
    if (r1)               sb.push_back(model_access(1, a1, d1, s1));
    if (first == 1 && r0) sb.push_back(model_access(0, a0, d0, s0));
    @(negedge clk);
    m0_if.valid = r0; m0_if.addr = a0; m0_if.wdata = d0; m0_if.wstrb = s0;
    m1_if.valid = r1; m1_if.addr = a1; m1_if.wdata = d1; m1_if.wstrb = s1;
    if (r0 ^ r1) begin
      #1;
      sa = r0 ? a0 : a1;
      ss = r0 ? s0 : s1;
      check("sram_en_grant", 32'(sram_en), 32'(in_rng(sa)));
      check("sram_we_grant", 32'(sram_we), in_rng(sa) ? 32'(ss) : 32'h0);
      if (in_rng(sa)) check("sram_addr_grant", 32'(sram_addr), sa >> 2);
    end
    p0 = r0; p1 = r1; n = 0;
    while ((p0 || p1) && n < 8) begin
      @(negedge clk);
      n++;
      if (m0_if.ready) begin p0 = 1'b0; m0_if.valid = 1'b0; end
      if (m1_if.ready) begin p1 = 1'b0; m1_if.valid = 1'b0; end
    end
    m0_if.valid = 1'b0;
    m1_if.valid = 1'b0;
    if (r0 || r1) check("latency", 32'(n), (r0 && r1) ? 32'd3 : 32'd1);
  endtask

  task automatic do_stream(input logic [31:0] a0, input logic [31:0] a1);
    int w, n, c0, c1, e0, e1;
    c0 = 0; c1 = 0; e0 = 0; e1 = 0; n = 0;
    for (int i = 0; i < 8; i++) begin
      w = pick(1'b1, 1'b1);
      sb.push_back(model_access(w, w == 1 ? a1 : a0, 32'h0, 4'h0));
      if (w == 1) e1++; else e0++;
    end
    @(negedge clk);
    m0_if.valid = 1'b1; m0_if.addr = a0; m0_if.wstrb = 4'h0;
    m1_if.valid = 1'b1; m1_if.addr = a1; m1_if.wstrb = 4'h0;
    while (c0 + c1 < 8 && n < 40) begin
      @(negedge clk);
      n++;
      if (m0_if.ready) c0++;
      if (m1_if.ready) c1++;
    end
    m0_if.valid = 1'b0;
    m1_if.valid = 1'b0;
    check("stream_m0_grants", 32'(c0), 32'(e0));
    check("stream_m1_grants", 32'(c1), 32'(e1));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return $urandom;
      1:       return 32'((MEM_WORDS - 1) * 4);
      2:       return 32'(MEM_WORDS * 4);
      default: return 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
    endcase
  endfunction

  function automatic logic [3:0] rand_strb();
    return ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m0_if.valid = 1'b0; m0_if.addr = 32'h0; m0_if.wdata = 32'h0; m0_if.wstrb = 4'h0;
    m1_if.valid = 1'b0; m1_if.addr = 32'h0; m1_if.wdata = 32'h0; m1_if.wstrb = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_m0_ready", 32'(m0_if.ready), 32'h0);
    check("rst_m1_ready", 32'(m1_if.ready), 32'h0);
    check("rst_m0_rdata", m0_if.rdata, 32'h0);
    check("rst_m1_rdata", m1_if.rdata, 32'h0);
    check("rst_sram_en", 32'(sram_en), 32'h0);
    check("rst_sram_we", 32'(sram_we), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    do_round(1'b1, 32'h14, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    do_round(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h10, 32'h1234_ABCD, 4'b0011);
    do_round(1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    do_round(1'b1, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    do_round(1'b1, 32'h14, 32'h0, 4'h0, 1'b1, 32'h10, 32'h0, 4'h0);
    do_stream(32'h14, 32'h10);
    do_round(1'b1, 32'h0002_0000, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    do_round(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 4'hF);
    do_round(1'b1, 32'hFFFF_FFFC, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);

    @(negedge clk);
    m1_if.valid = 1'b1; m1_if.addr = 32'h20; m1_if.wstrb = 4'h0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_m1_ready", 32'(m1_if.ready), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    m1_if.valid = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    model_lg = 1;
    do_round(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h20, 32'h0, 4'h0);

    for (int i = 0; i < 150; i++) begin
      bit r0, r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) @(negedge clk);
      else do_round(r0, rand_addr(), $urandom, rand_strb(), r1, rand_addr(), $urandom, rand_strb());
    end

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
